// File: rtl/kd_internal_node_tree.sv
// rtl/kd_internal_node_tree.sv - 6-level KD-tree internal node store with two pipelined root-to-leaf query ports
// Each pipeline stage tracks the node offset within its level; after LEVELS decisions that offset is the leaf index.
module kd_internal_node_tree #(
  parameter int INTERNAL_WIDTH = 22,
  parameter int PATCH_WIDTH    = 55,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 11,
  parameter int LEVELS         = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fsm_enable,
  input  logic                      sender_enable,
  input  logic [INTERNAL_WIDTH-1:0] sender_data,
  input  logic                      patch_en,
  input  logic [PATCH_WIDTH-1:0]    patch_in,
  input  logic                      patch_two_en,
  input  logic [PATCH_WIDTH-1:0]    patch_in_two,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
  output logic                      receiver_en,
  output logic                      receiver_two_en
);

  localparam int NODES = (1 << LEVELS) - 1;
  localparam int NCOMP = PATCH_WIDTH / DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] NCOMP_W = DATA_WIDTH'(NCOMP);

  logic [LEVELS-1:0] ptr;
  logic              load_fire;

  logic [1:0]                                       q_en;
  logic [1:0][PATCH_WIDTH-1:0]                      q_patch;
  logic [1:0][LEVELS:0]                             vld;
  logic [1:0][LEVELS-1:0][PATCH_WIDTH-1:0]          pat;
  logic [1:0][LEVELS:0][LEVELS-1:0]                 off;
  logic [1:0][LEVELS-1:0][INTERNAL_WIDTH-1:0]       node;
  logic [1:0][LEVELS-1:0]                           go_right;
  logic [1:0][ADDRESS_WIDTH-1:0]                    leaf_q;
  logic [1:0]                                       rcv_q;

  assign q_en    = {patch_two_en, patch_en};
  assign q_patch = {patch_in_two, patch_in};

  // Pointer parks at NODES so surplus words from the sender are dropped.
  assign load_fire = fsm_enable && sender_enable && (ptr != LEVELS'(NODES));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ptr <= '0;
    end else if (!fsm_enable) begin
      ptr <= '0;
    end else if (load_fire) begin
      ptr <= ptr + 1'b1;
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    if (l == 0) begin : g_root
      logic [INTERNAL_WIDTH-1:0] root;

      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          root <= '0;
        end else if (load_fire && (ptr == '0)) begin
          root <= sender_data;
        end
      end

      assign node[0][0] = root;
      assign node[1][0] = root;
    end else begin : g_bank
      localparam int SIZE = 1 << l;
      localparam logic [LEVELS-1:0] BASE_P = LEVELS'(SIZE - 1);
      localparam logic [LEVELS-1:0] END_P  = LEVELS'(2 * SIZE - 1);

      logic [INTERNAL_WIDTH-1:0] bank [SIZE];
      logic [l-1:0]              woff;
      logic                      hit;

      assign hit  = (ptr >= BASE_P) && (ptr < END_P);
      assign woff = ptr[l-1:0] - BASE_P[l-1:0];

      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          for (int i = 0; i < SIZE; i++) begin
            bank[i] <= '0;
          end
        end else if (load_fire && hit) begin
          bank[woff] <= sender_data;
        end
      end

      assign node[0][l] = bank[off[0][l][l-1:0]];
      assign node[1][l] = bank[off[1][l][l-1:0]];
    end
  end

  // Out-of-range dimension selectors fall back to component 0.
  always_comb begin
    logic [DATA_WIDTH-1:0] dim;
    logic [DATA_WIDTH-1:0] cmp;
    logic [DATA_WIDTH-1:0] med;
    int                    sel;
    go_right = '0;
    dim      = '0;
    cmp      = '0;
    med      = '0;
    sel      = 0;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < LEVELS; s++) begin
        dim = node[p][s][DATA_WIDTH-1:0];
        med = node[p][s][INTERNAL_WIDTH-1:DATA_WIDTH];
        sel = (dim < NCOMP_W) ? int'(dim) : 0;
        cmp = pat[p][s][DATA_WIDTH-1:0];
        for (int c = 0; c < NCOMP; c++) begin
          if (sel == c) begin
            cmp = pat[p][s][c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        go_right[p][s] = ($signed(cmp) >= $signed(med));
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld    <= '0;
      pat    <= '0;
      off    <= '0;
      leaf_q <= '0;
      rcv_q  <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld[p]    <= {vld[p][LEVELS-1:0], q_en[p]};
        pat[p][0] <= q_patch[p];
        off[p][0] <= '0;
        for (int s = 0; s < LEVELS - 1; s++) begin
          pat[p][s+1] <= pat[p][s];
        end
        for (int s = 0; s < LEVELS; s++) begin
          off[p][s+1] <= (off[p][s] << 1) | LEVELS'(go_right[p][s]);
        end
        rcv_q[p] <= vld[p][LEVELS];
        if (vld[p][LEVELS]) begin
          leaf_q[p] <= ADDRESS_WIDTH'(off[p][LEVELS]);
        end
      end
    end
  end

  assign leaf_index      = leaf_q[0];
  assign leaf_index_two  = leaf_q[1];
  assign receiver_en     = rcv_q[0];
  assign receiver_two_en = rcv_q[1];

endmodule

// File: tb/tb_kd_internal_node_tree.sv
// tb/tb_kd_internal_node_tree.sv - directed and randomized bench for kd_internal_node_tree against a heap-walk model
module tb_kd_internal_node_tree;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fsm_enable = 1'b0;
  logic        sender_enable = 1'b0;
  logic [21:0] sender_data = '0;
  logic        patch_en = 1'b0;
  logic [54:0] patch_in = '0;
  logic        patch_two_en = 1'b0;
  logic [54:0] patch_in_two = '0;
  logic [7:0]  leaf_index;
  logic [7:0]  leaf_index_two;
  logic        receiver_en;
  logic        receiver_two_en;

  kd_internal_node_tree dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fsm_enable      (fsm_enable),
    .sender_enable   (sender_enable),
    .sender_data     (sender_data),
    .patch_en        (patch_en),
    .patch_in        (patch_in),
    .patch_two_en    (patch_two_en),
    .patch_in_two    (patch_in_two),
    .leaf_index      (leaf_index),
    .leaf_index_two  (leaf_index_two),
    .receiver_en     (receiver_en),
    .receiver_two_en (receiver_two_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int leaf;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   mdim [63];
  int   mmed [63];
  int   mptr = 0;
  int   last1 = 0;
  int   last2 = 0;
  exp_t e1 [$];
  exp_t e2 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Heap walk: node n has children 2n+1 (left, comp < median) and 2n+2 (right).
  function automatic int model_leaf(input int c0, input int c1, input int c2, input int c3, input int c4);
    int c [5];
    int n;
    int d;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3; c[4] = c4;
    n = 0;
    for (int lvl = 0; lvl < 6; lvl++) begin
      d = (mdim[n] > 4) ? 0 : mdim[n];
      n = (c[d] < mmed[n]) ? 2 * n + 1 : 2 * n + 2;
    end
    return n - 63;
  endfunction

  function automatic logic [54:0] pack(input int c0, input int c1, input int c2, input int c3, input int c4);
    return {11'(c4), 11'(c3), 11'(c2), 11'(c1), 11'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    patch_en     = 1'b0;
    patch_two_en = 1'b0;
    if (e1.size() > 0 && e1[0].due == cyc) begin
      chk("rcv1_pulse", 32'(receiver_en), 32'd1);
      chk("leaf1", 32'(leaf_index), 32'(e1[0].leaf));
      last1 = e1[0].leaf;
      void'(e1.pop_front());
    end else begin
      chk("rcv1_idle", 32'(receiver_en), 32'd0);
      chk("leaf1_hold", 32'(leaf_index), 32'(last1));
    end
    if (e2.size() > 0 && e2[0].due == cyc) begin
      chk("rcv2_pulse", 32'(receiver_two_en), 32'd1);
      chk("leaf2", 32'(leaf_index_two), 32'(e2[0].leaf));
      last2 = e2[0].leaf;
      void'(e2.pop_front());
    end else begin
      chk("rcv2_idle", 32'(receiver_two_en), 32'd0);
      chk("leaf2_hold", 32'(leaf_index_two), 32'(last2));
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input int dim, input int med);
    fsm_enable    = 1'b1;
    sender_enable = 1'b1;
    sender_data   = {11'(med), 11'(dim)};
    if (mptr < 63) begin
      mdim[mptr] = dim;
      mmed[mptr] = med;
      mptr++;
    end
    tick();
    sender_enable = 1'b0;
  endtask

  task automatic unload();
    fsm_enable = 1'b0;
    mptr       = 0;
    tick();
  endtask

  task automatic q1(input int c0, input int c1, input int c2, input int c3, input int c4);
    exp_t t;
    patch_en = 1'b1;
    patch_in = pack(c0, c1, c2, c3, c4);
    t.due  = cyc + 8;
    t.leaf = model_leaf(c0, c1, c2, c3, c4);
    e1.push_back(t);
  endtask

  task automatic q2(input int c0, input int c1, input int c2, input int c3, input int c4);
    exp_t t;
    patch_two_en = 1'b1;
    patch_in_two = pack(c0, c1, c2, c3, c4);
    t.due  = cyc + 8;
    t.leaf = model_leaf(c0, c1, c2, c3, c4);
    e2.push_back(t);
  endtask

  function automatic int rv(input int r);
    return int'($urandom_range(0, 2 * r - 1)) - r;
  endfunction

  task automatic random_round(input int r, input int cycles);
    unload();
    for (int i = 0; i < 63; i++) load(int'($urandom_range(0, 7)), rv(r));
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 3) != 0) q1(rv(r), rv(r), rv(r), rv(r), rv(r));
      if ($urandom_range(0, 3) != 0) q2(rv(r), rv(r), rv(r), rv(r), rv(r));
      tick();
    end
    drain(9);
  endtask

  initial begin
    for (int i = 0; i < 63; i++) begin
      mdim[i] = 0;
      mmed[i] = 0;
    end
    #2 rst_n = 1'b1;
    #1;
    chk("reset_leaf1", 32'(leaf_index), 32'd0);
    chk("reset_leaf2", 32'(leaf_index_two), 32'd0);
    chk("reset_rcv1", 32'(receiver_en), 32'd0);
    chk("reset_rcv2", 32'(receiver_two_en), 32'd0);
    #9 rst_n = 1'b0;

    // All-zero tree on dim 0: positive goes fully right, negative fully left.
    for (int i = 0; i < 63; i++) load(0, 0);
    q1(5, 0, 0, 0, 0); tick();
    q1(-1, 0, 0, 0, 0); tick();
    drain(9);

    // Tie with median goes right, both ports in the same cycle.
    q1(0, 0, 0, 0, 0); q2(0, 0, 0, 0, 0); tick();
    drain(9);

    unload();
    for (int i = 0; i < 63; i++) load(1, 100);
    q2(0, -300, 0, 0, 0); tick();
    drain(9);

    unload();
    for (int i = 0; i < 63; i++) load(0, 0);
    q1(5, 0, 0, 0, 0); tick();
    q1(-1, 0, 0, 0, 0); tick();
    q1(5, 0, 0, 0, 0); tick();
    drain(12);

    // Surplus words would flip the root if the pointer wrapped.
    unload();
    for (int i = 0; i < 63; i++) load(0, 0);
    for (int i = 0; i < 7; i++) load(0, -1000);
    q1(-1, 0, 0, 0, 0); q2(5, 0, 0, 0, 0); tick();
    drain(9);

    random_round(1024, 150);
    random_round(4, 150);

    // Reset mid-pipeline: in-flight queries vanish and the node store clears.
    q1(rv(1024), rv(1024), 0, 0, 0); q2(rv(1024), 0, 0, 0, 0); tick();
    q1(3, 0, 0, 0, 0); tick();
    tick(); tick();
    #2 rst_n = 1'b1;
    #1;
    e1.delete();
    e2.delete();
    last1 = 0;
    last2 = 0;
    mptr  = 0;
    for (int i = 0; i < 63; i++) begin
      mdim[i] = 0;
      mmed[i] = 0;
    end
    chk("midreset_leaf1", 32'(leaf_index), 32'd0);
    chk("midreset_leaf2", 32'(leaf_index_two), 32'd0);
    chk("midreset_rcv1", 32'(receiver_en), 32'd0);
    chk("midreset_rcv2", 32'(receiver_two_en), 32'd0);
    tick();
    rst_n = 1'b0;
    drain(10);
    q1(-1, 0, 0, 0, 0); q2(0, 0, 0, 0, 0); tick();
    drain(9);

    chk("q1_drained", 32'(e1.size()), 32'd0);
    chk("q2_drained", 32'(e2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
